// File: rtl/can_bit_stuffer_if.sv
// Bit-level link between the TX frame serializer and the CAN bit stuffer.
// Ports: bit_tick/load/din flow into the stuffer. din_ack, dout, stuff_active and run_cnt flow back out.
// Modports: master = serializer/driver side, slave = the stuffer itself.
interface can_bit_stuffer_if #(
    parameter int STUFF_LEN = 5
);
    localparam int CW = $clog2(STUFF_LEN + 1);

    logic          bit_tick;
    logic          load;
    logic          din;
    logic          din_ack;
    logic          dout;
    logic          stuff_active;
    logic [CW-1:0] run_cnt;

    modport master (
        output bit_tick, load, din,
        input  din_ack, dout, stuff_active, run_cnt
    );

    modport slave (
        input  bit_tick, load, din,
        output din_ack, dout, stuff_active, run_cnt
    );
endinterface

// File: rtl/can_bit_stuffer.sv
// Transmit-side CAN bit stuffer: after STUFF_LEN identical bits, inserts one complementary bit.
// Latency: din sampled on a bit_tick edge drives dout from that edge until the next tick.
// Backpressure: din_ack is low on the tick that carries a stuff bit, so upstream holds din and
//   re-presents it on the next tick.
// Ports: clk, rst_n (asynchronous, active-high despite the name), and bus (slave modport).
//   On bus, bit_tick/load/din are inputs. din_ack is combinational.
//   dout/stuff_active/run_cnt are registered.
module can_bit_stuffer #(
    parameter int STUFF_LEN  = 5,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    can_bit_stuffer_if.slave   bus
);
    localparam int CW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic          dout_q, dout_nxt;
    logic          last_q, last_nxt;     // previous transmitted bit, data or stuff
    logic          stuff_q, stuff_nxt;
    logic [CW-1:0] run_q, run_nxt;
    logic          ack;
    logic          stuff_due;

    assign stuff_due = (run_q == CW'(STUFF_LEN));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            dout_q  <= IDLE_LEVEL;
            last_q  <= IDLE_LEVEL;
            stuff_q <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_nxt;
            dout_q  <= dout_nxt;
            last_q  <= last_nxt;
            stuff_q <= stuff_nxt;
            run_q   <= run_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        dout_nxt  = dout_q;
        last_nxt  = last_q;
        stuff_nxt = stuff_q;
        run_nxt   = run_q;
        ack       = 1'b0;

        if (bus.bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        dout_nxt  = bus.din;
                        last_nxt  = bus.din;
                        run_nxt   = CW'(1);
                        stuff_nxt = 1'b0;
                        ack       = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        dout_nxt  = IDLE_LEVEL;
                        run_nxt   = '0;
                        stuff_nxt = 1'b0;
                    end
                end
                DATA, STUFF: begin
                    // A due stuff bit wins over load, so a frame whose last bits form a
                    // full run still gets its trailing stuff bit before returning to idle.
                    if (stuff_due) begin
                        dout_nxt  = ~last_q;
                        last_nxt  = ~last_q;
                        run_nxt   = CW'(1);   // the stuff bit opens the next run
                        stuff_nxt = 1'b1;
                        state_nxt = STUFF;
                    end else if (bus.load) begin
                        dout_nxt  = bus.din;
                        last_nxt  = bus.din;
                        run_nxt   = (bus.din == last_q) ? run_q + CW'(1) : CW'(1);
                        stuff_nxt = 1'b0;
                        ack       = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        dout_nxt  = IDLE_LEVEL;
                        run_nxt   = '0;
                        stuff_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    dout_nxt  = IDLE_LEVEL;
                    run_nxt   = '0;
                    stuff_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.din_ack      = ack;
    assign bus.dout         = dout_q;
    assign bus.stuff_active = stuff_q;
    assign bus.run_cnt      = run_q;
endmodule

// File: tb/tb_can_bit_stuffer.sv
module tb_can_bit_stuffer;
    logic clk;
    logic rst_n;

    can_bit_stuffer_if #(.STUFF_LEN(5)) bus();

    can_bit_stuffer #(.STUFF_LEN(5), .IDLE_LEVEL(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dout;
        logic       stuff;
        logic       ack;
        logic [2:0] rc;
    } exp_t;

    exp_t  sb[$];
    exp_t  hold;          // expected registered outputs between ticks
    bit    hold_vld;
    int    checks;
    int    errors;
    string cur_test;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s at %0t: got %0d required %0d", cur_test, name, $time, act, req);
        end
    endtask

    // Monitor: on tick cycles check din_ack against the queue head, then after the edge
    // pop and check the registered outputs; on other cycles the outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.bit_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tick", 8'd1, 8'd0);
                end else begin
                    e = sb[0];
                    chk("din_ack", {7'd0, bus.din_ack}, {7'd0, e.ack});
                    @(posedge clk);
                    #1;
                    e = sb.pop_front();
                    chk("dout", {7'd0, bus.dout}, {7'd0, e.dout});
                    chk("stuff_active", {7'd0, bus.stuff_active}, {7'd0, e.stuff});
                    chk("run_cnt", {5'd0, bus.run_cnt}, {5'd0, e.rc});
                    hold = e;
                end
            end else if (hold_vld) begin
                chk("hold_dout", {7'd0, bus.dout}, {7'd0, hold.dout});
                chk("hold_stuff", {7'd0, bus.stuff_active}, {7'd0, hold.stuff});
                chk("hold_run_cnt", {5'd0, bus.run_cnt}, {5'd0, hold.rc});
                chk("hold_din_ack", {7'd0, bus.din_ack}, 8'd0);
            end
        end
    end

    // One tick: drive at a falling edge, push the expectation, drop bit_tick a cycle later.
    task automatic tick(input logic ld, input logic d, input logic e_dout,
                        input logic e_stuff, input logic e_ack, input logic [2:0] e_rc);
        exp_t e;
        bus.bit_tick = 1'b1;
        bus.load     = ld;
        bus.din      = d;
        e.dout  = e_dout;
        e.stuff = e_stuff;
        e.ack   = e_ack;
        e.rc    = e_rc;
        sb.push_back(e);
        @(negedge clk);
        bus.bit_tick = 1'b0;
    endtask

    // Idle clocks with load/din wiggling; none of it may reach the outputs.
    task automatic gap(input int n);
        for (int g = 0; g < n; g++) begin
            bus.load = 1'($urandom);
            bus.din  = 1'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        hold_vld = 1'b0;
        cur_test = "init";
        bus.bit_tick = 1'b0;
        bus.load     = 1'b0;
        bus.din      = 1'b0;
        rst_n        = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dout", {7'd0, bus.dout}, 8'd1);
        chk("rst_stuff", {7'd0, bus.stuff_active}, 8'd0);
        chk("rst_run_cnt", {5'd0, bus.run_cnt}, 8'd0);
        hold.dout = 1'b1; hold.stuff = 1'b0; hold.ack = 1'b0; hold.rc = 3'd0;
        hold_vld = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);

        // Six zeros: five pass, then a stuff 1 while din is held, then the held 0.
        cur_test = "zeros";
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'(i));
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        // Alternating bits never stuff.
        cur_test = "alternate";
        for (int i = 0; i < 16; i++) tick(1'b1, 1'(i % 2), 1'(i % 2), 1'b0, 1'b1, 3'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        // 1,1,1,1,1,0,0,0,0,1: the stuff 0 joins the four data 0s, forcing a stuff 1.
        cur_test = "chained";
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'(i));
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        for (int i = 2; i <= 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'(i));
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        // Frame ends exactly on a full run: trailing stuff bit, then idle.
        cur_test = "eof_stuff";
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'(i));
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

        // Asynchronous reset in the middle of a stuff bit, away from any clock edge.
        cur_test = "async_reset";
        for (int i = 1; i <= 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'(i));
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("arst_dout", {7'd0, bus.dout}, 8'd1);
        chk("arst_stuff", {7'd0, bus.stuff_active}, 8'd0);
        chk("arst_run_cnt", {5'd0, bus.run_cnt}, 8'd0);
        hold.dout = 1'b1; hold.stuff = 1'b0; hold.ack = 1'b0; hold.rc = 3'd0;
        bus.load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        // Fresh frame: the discarded run must not carry over.
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        // Ticks spaced by 7 clocks with random load/din in between.
        cur_test = "gapped";
        gap(7);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'(i));
            gap(7);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
        gap(7);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
        gap(7);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        gap(7);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        gap(3);

        cur_test = "drain";
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        if (sb.size() != 0) chk("scoreboard_drain", 8'(sb.size()), 8'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
